// File: rtl/mprj2_pwr_pkg.sv
// Shared types for the user-domain-2 power-good monitor.
// State encoding is visible to software via state_o.
package mprj2_pwr_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2,
    ST_FAULT  = 2'd3
  } pwr_state_e;

  // All-ones value for a w-bit saturating counter (w up to 32).
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mprj2_hi_sync.sv
// Multi-flop level synchronizer for tie-high style inputs.
// Resets to 0 so a missing domain reads as powered down.
module mprj2_hi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/mprj2_power_good_monitor.sv
// Qualifies the mprj2 tie-high into a debounced power-good,
// interface enable, sticky fault and glitch counter.
module mprj2_power_good_monitor
  import mprj2_pwr_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               mprj2_hi,
  input  logic               force_off,
  input  logic               clear_fault,
  output logic               mprj2_pwr_good,
  output logic               mprj2_ena,
  output logic               mprj2_fault,
  output logic [CNT_W-1:0]   glitch_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int SCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST =
    SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_MAX =
    CNT_W'(sat_max(CNT_W));

  logic           hi_s;
  pwr_state_e     state;
  pwr_state_e     state_nx;
  logic [SCW-1:0] settle_cnt;
  logic [SCW-1:0] settle_nx;
  logic           glitch_inc;

  mprj2_hi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d  (mprj2_hi),
    .q  (hi_s)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_OFF;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    settle_nx  = settle_cnt;
    glitch_inc = 1'b0;
    unique case (state)
      ST_OFF: begin
        if (!force_off && hi_s) begin
          state_nx  = ST_SETTLE;
          settle_nx = '0;
        end
      end
      ST_SETTLE: begin
        if (force_off) begin
          state_nx = ST_OFF;
        end else if (!hi_s) begin
          state_nx   = ST_OFF;
          glitch_inc = 1'b1;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nx = ST_ON;
        end else begin
          settle_nx = settle_cnt + 1'b1;
        end
      end
      ST_ON: begin
        // force_off wins so a commanded shutdown is not a fault
        if (force_off) begin
          state_nx = ST_OFF;
        end else if (!hi_s) begin
          state_nx   = ST_FAULT;
          glitch_inc = 1'b1;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_nx = ST_OFF;
        end
      end
      default: state_nx = ST_OFF;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      glitch_cnt <= '0;
    end else if (glitch_inc && glitch_cnt != GLITCH_MAX) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

  assign mprj2_pwr_good = (state == ST_ON);
  assign mprj2_ena      = (state == ST_ON);
  assign mprj2_fault    = (state == ST_FAULT);
  assign state_o        = state;

endmodule

// File: tb/tb_mprj2_power_good_monitor.sv
// Bench for mprj2_power_good_monitor: directed table,
// hand sequences and random stimulus against a reference model.
module tb_mprj2_power_good_monitor;

  localparam int SYNC = 2;
  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       mprj2_hi;
  logic       force_off;
  logic       clear_fault;
  logic       pg, ena, fault;
  logic [7:0] gc;
  logic [1:0] st;
  logic       pg2, ena2, fault2;
  logic [1:0] gc2;
  logic [1:0] st2;

  always #5 clk = ~clk;

  mprj2_power_good_monitor dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .mprj2_hi      (mprj2_hi),
    .force_off     (force_off),
    .clear_fault   (clear_fault),
    .mprj2_pwr_good(pg),
    .mprj2_ena     (ena),
    .mprj2_fault   (fault),
    .glitch_cnt    (gc),
    .state_o       (st)
  );

  mprj2_power_good_monitor #(.CNT_W(2)) dut2 (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .mprj2_hi      (mprj2_hi),
    .force_off     (force_off),
    .clear_fault   (clear_fault),
    .mprj2_pwr_good(pg2),
    .mprj2_ena     (ena2),
    .mprj2_fault   (fault2),
    .glitch_cnt    (gc2),
    .state_o       (st2)
  );

  typedef struct {
    bit hi;
    bit frc;
    bit clr;
    int n;
    int st;
    int gl;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: mode 0=off 1=settling 2=on 3=fault,
  // age = cycles already spent settling, glitches unbounded.
  int   m_mode;
  int   m_age;
  int   m_glitch;
  bit   m_hist[$];

  function automatic void add(bit hi, bit frc, bit clr,
                              int n, int s, int gl);
    vec_t v;
    v.hi = hi; v.frc = frc; v.clr = clr;
    v.n = n; v.st = s; v.gl = gl;
    tbl.push_back(v);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_age = 0;
    m_glitch = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit seen;
    if (wb_rst_i) begin
      model_reset();
      return;
    end
    seen = m_hist.pop_front();
    m_hist.push_back(mprj2_hi);
    case (m_mode)
      0: if (!force_off && seen) begin
        m_mode = 1;
        m_age = 0;
      end
      1: if (force_off) m_mode = 0;
      else if (!seen) begin
        m_mode = 0;
        m_glitch++;
      end else if (m_age + 1 == SETTLE) m_mode = 2;
      else m_age++;
      2: if (force_off) m_mode = 0;
      else if (!seen) begin
        m_mode = 3;
        m_glitch++;
      end
      default: if (clear_fault) m_mode = 0;
    endcase
  endtask

  task automatic check(string name);
    int  g8, g2;
    bit  eon, eflt;
    logic [1:0] es;
    g8 = (m_glitch > 255) ? 255 : m_glitch;
    g2 = (m_glitch > 3) ? 3 : m_glitch;
    eon = (m_mode == 2);
    eflt = (m_mode == 3);
    es = m_mode[1:0];
    checks++;
    if (st !== es || pg !== eon || ena !== eon ||
        fault !== eflt || gc !== g8[7:0] ||
        st2 !== es || pg2 !== eon || ena2 !== eon ||
        fault2 !== eflt || gc2 !== g2[1:0]) begin
      $display("FAIL %s t=%0t: got st=%0d pg=%b ena=%b flt=%b gc=%0d st2=%0d gc2=%0d, want st=%0d pg=%b flt=%b gc=%0d gc2=%0d",
               name, $time, st, pg, ena, fault, gc, st2, gc2,
               es, eon, eflt, g8, g2);
    end else begin
      passed++;
    end
  endtask

  task automatic tick(string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(name);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    mprj2_hi = 1'b0;
    force_off = 1'b0;
    clear_fault = 1'b0;
    model_reset();
    #1;
    check("reset");
    tick("reset_hold");
    tick("reset_hold");

    // Directed table: {hi, force, clear, cycles, state, glitches}
    add(1, 0, 0, 18, 1, 0);
    add(1, 0, 0, 1, 2, 0);
    add(0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 1, 3, 1);
    add(0, 0, 0, 2, 3, 1);
    add(1, 0, 0, 4, 3, 1);
    add(1, 0, 1, 1, 0, 1);
    add(1, 0, 0, 16, 1, 1);
    add(1, 0, 0, 1, 2, 1);
    add(1, 0, 1, 1, 2, 1);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 10, 0, 1);
    add(1, 0, 0, 11, 1, 1);
    add(0, 0, 0, 2, 1, 1);
    add(0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 2, 0, 2);
    add(1, 0, 0, 16, 1, 2);
    add(1, 0, 0, 1, 2, 2);
    add(0, 0, 0, 2, 2, 2);
    add(0, 1, 0, 1, 0, 2);
    add(1, 1, 0, 20, 0, 2);
    add(1, 0, 0, 1, 1, 2);
    add(1, 0, 0, 15, 1, 2);
    add(1, 0, 0, 1, 2, 2);
    add(0, 0, 0, 2, 2, 2);
    add(0, 0, 1, 1, 3, 3);
    add(1, 0, 1, 1, 0, 3);
    add(1, 0, 0, 1, 0, 3);
    add(1, 0, 0, 16, 1, 3);
    add(1, 0, 0, 1, 2, 3);

    wb_rst_i = 1'b0;
    foreach (tbl[i]) begin
      mprj2_hi = tbl[i].hi;
      force_off = tbl[i].frc;
      clear_fault = tbl[i].clr;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick("tbl_step");
        clear_fault = 1'b0;
      end
      checks++;
      if (st !== tbl[i].st[1:0] || gc !== tbl[i].gl[7:0])
        $display("FAIL tbl_row%0d: got st=%0d gc=%0d, want st=%0d gc=%0d",
                 i, st, gc, tbl[i].st, tbl[i].gl);
      else
        passed++;
    end

    // Asynchronous reset while ON, checked before the next edge
    @(posedge clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (pg !== 1'b0 || ena !== 1'b0 || fault !== 1'b0 ||
        gc !== 8'd0 || st !== 2'd0)
      $display("FAIL async_rst: got pg=%b ena=%b flt=%b gc=%0d st=%0d, want all 0",
               pg, ena, fault, gc, st);
    else
      passed++;
    model_reset();
    check("async_rst_model");
    @(negedge clk);
    tick("rst_hold");
    wb_rst_i = 1'b0;
    mprj2_hi = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick("post_rst");
      if (k == 18 || k == 19) begin
        checks++;
        if (pg !== (k == 19))
          $display("FAIL post_rst_edge%0d: got pg=%b, want %b",
                   k, pg, (k == 19));
        else
          passed++;
      end
    end

    // Saturation of the 2-bit counter across five settle aborts
    force_off = 1'b1;
    tick("sat_off");
    mprj2_hi = 1'b0;
    repeat (3) tick("sat_flush");
    force_off = 1'b0;
    for (int a = 0; a < 5; a++) begin
      mprj2_hi = 1'b1;
      repeat (4) tick("sat_rise");
      mprj2_hi = 1'b0;
      repeat (3) tick("sat_abort");
    end
    checks++;
    if (gc2 !== 2'd3 || gc !== 8'd5)
      $display("FAIL saturate: got gc2=%0d gc=%0d, want gc2=3 gc=5",
               gc2, gc);
    else
      passed++;

    // Random stimulus against the reference model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) mprj2_hi = ~mprj2_hi;
      r = $urandom_range(0, 99);
      if (!force_off && r < 2) force_off = 1'b1;
      else if (force_off && r < 15) force_off = 1'b0;
      clear_fault = ($urandom_range(0, 99) < 6);
      wb_rst_i = ($urandom_range(0, 999) < 3);
      tick("random");
    end
    wb_rst_i = 1'b0;
    clear_fault = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
